// File: rtl/rate_pkg.sv
// rate_pkg: rate codes, controller states and strobe cascade ratios
package rate_pkg;
  localparam logic [1:0] RATE_1HZ = 2'b00;
  localparam logic [1:0] RATE_20HZ = 2'b01;
  localparam logic [1:0] RATE_50HZ = 2'b10;
  localparam logic [1:0] RATE_100HZ = 2'b11;
  localparam int DIV_50 = 2;
  localparam int DIV_20 = 5;
  localparam int DIV_1 = 100;
  typedef enum logic {IDLE, PEND} state_t;
endpackage

// File: rtl/tick_divider.sv
// tick_divider: prescaler and 2/5/100 cascade producing four phase-aligned registered strobes
module tick_divider
  import rate_pkg::*;
#(
  parameter int DIV = 500000
) (
  input  logic       clk,
  input  logic       rst,
  output logic       t,
  output logic [3:0] nxt,
  output logic [3:0] stb
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt;
  logic          c2;
  logic [2:0]    c5;
  logic [6:0]    c100;
  // Base tick and the strobe values loaded on it; bit index matches the sel encoding
  always_comb begin
    t = cnt == CW'(DIV - 1);
    nxt = t ? {1'b1, c2 == 1'(DIV_50 - 1), c5 == 3'(DIV_20 - 1), c100 == 7'(DIV_1 - 1)} : 4'b0;
  end
  // Prescaler always runs; the cascade advances only on the base tick
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      c2 <= '0;
      c5 <= '0;
      c100 <= '0;
      stb <= '0;
    end else begin
      cnt <= t ? '0 : cnt + 1'b1;
      stb <= nxt;
      if (t) begin
        c2 <= c2 == 1'(DIV_50 - 1) ? '0 : c2 + 1'b1;
        c5 <= c5 == 3'(DIV_20 - 1) ? '0 : c5 + 1'b1;
        c100 <= c100 == 7'(DIV_1 - 1) ? '0 : c100 + 1'b1;
      end
    end
endmodule

// File: rtl/rate_sel_ctrl.sv
// rate_sel_ctrl: steps the selected strobe rate from button edges, committing only on base ticks
module rate_sel_ctrl
  import rate_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BASE_HZ = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       hold,
  output logic       ena1hz,
  output logic       ena20hz,
  output logic       ena50hz,
  output logic       ena100hz,
  output logic       ena_db,
  output logic [1:0] sel,
  output logic       busy
);
  localparam int DIV = CLK_HZ / BASE_HZ;
  logic       t;
  logic [3:0] nxt;
  logic [3:0] stb;
  logic       btn_next_d;
  logic       btn_prev_d;
  logic       nx;
  logic       pv;
  state_t     state;
  state_t     state_n;
  logic [1:0] pend;
  logic [1:0] pend_n;
  logic [1:0] base;
  logic [1:0] sel_n;
  tick_divider #(.DIV(DIV)) u_div (
    .clk(clk),
    .rst(rst),
    .t(t),
    .nxt(nxt),
    .stb(stb)
  );
  assign {ena100hz, ena50hz, ena20hz, ena1hz} = stb;
  // Edge detect with simultaneous next/prev cancelling; pending target folds in new edges before a commit
  always_comb begin
    nx = btn_next & ~btn_next_d & ~(btn_prev & ~btn_prev_d);
    pv = btn_prev & ~btn_prev_d & ~(btn_next & ~btn_next_d);
    base = state == IDLE ? sel : pend;
    pend_n = nx ? base + 2'd1 : pv ? base - 2'd1 : base;
    state_n = state == IDLE ? ((nx | pv) ? PEND : IDLE) : (t ? IDLE : PEND);
    sel_n = (state == PEND && t) ? pend_n : sel;
  end
  // Button history resets high so a button held through reset yields no edge; ena_db uses pre-commit sel
  always_ff @(posedge clk)
    if (rst) begin
      btn_next_d <= 1'b1;
      btn_prev_d <= 1'b1;
      state <= IDLE;
      pend <= RATE_1HZ;
      sel <= RATE_1HZ;
      busy <= 1'b0;
      ena_db <= 1'b0;
    end else begin
      btn_next_d <= btn_next;
      btn_prev_d <= btn_prev;
      state <= state_n;
      pend <= pend_n;
      sel <= sel_n;
      busy <= state_n == PEND;
      ena_db <= ~hold & nxt[sel];
    end
endmodule

// File: tb/tb_rate_sel_ctrl.sv
// tb_rate_sel_ctrl: scoreboard bench for rate_sel_ctrl with DIV=10
module tb_rate_sel_ctrl;
  import rate_pkg::*;
  typedef struct {
    int         cyc;
    logic       e1;
    logic       e20;
    logic       e50;
    logic       db;
    logic [1:0] sel;
  } exp_t;
  logic       clk = 0;
  logic       rst = 1;
  logic       btn_next = 0;
  logic       btn_prev = 0;
  logic       hold = 0;
  logic       ena1hz;
  logic       ena20hz;
  logic       ena50hz;
  logic       ena100hz;
  logic       ena_db;
  logic [1:0] sel;
  logic       busy;
  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         k = 0;
  logic [1:0] sel_m = RATE_1HZ;
  rate_sel_ctrl #(.CLK_HZ(1000), .BASE_HZ(100)) dut (
    .clk(clk),
    .rst(rst),
    .btn_next(btn_next),
    .btn_prev(btn_prev),
    .hold(hold),
    .ena1hz(ena1hz),
    .ena20hz(ena20hz),
    .ena50hz(ena50hz),
    .ena100hz(ena100hz),
    .ena_db(ena_db),
    .sel(sel),
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
  task automatic chk(input string n, input int a, input int r);
    checks++;
    if (a != r) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at cyc=%0d", n, a, r, cyc);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  function automatic logic strobe_of(input logic [1:0] s, input int n);
    return s == RATE_1HZ ? (n % 100 == 99) : s == RATE_20HZ ? (n % 5 == 4) :
           s == RATE_50HZ ? (n % 2 == 1) : 1'b1;
  endfunction
  task automatic reset_chk();
    chk("rst_ena1hz", ena1hz, 0);
    chk("rst_ena20hz", ena20hz, 0);
    chk("rst_ena50hz", ena50hz, 0);
    chk("rst_ena100hz", ena100hz, 0);
    chk("rst_ena_db", ena_db, 0);
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
  endtask
  task automatic period(input int act, input logic [1:0] new_sel);
    int used = 0;
    case (act)
      1, 2: begin
        cycles(3);
        if (act == 1) btn_next = 1;
        else btn_prev = 1;
        cycles(1);
        chk("busy_after_edge", busy, 1);
        chk("sel_before_commit", sel, sel_m);
        btn_next = 0;
        btn_prev = 0;
        used = 4;
      end
      3: begin
        for (int i = 0; i < 4; i++) begin
          btn_next = 1;
          cycles(1);
          btn_next = 0;
          cycles(1);
        end
        chk("busy_after_burst", busy, 1);
        used = 8;
      end
      4: begin
        cycles(3);
        btn_next = 1;
        btn_prev = 1;
        cycles(1);
        chk("busy_both_edges", busy, 0);
        chk("sel_both_edges", sel, sel_m);
        btn_next = 0;
        btn_prev = 0;
        used = 4;
      end
      default: ;
    endcase
    q.push_back('{10 * (k + 1), k % 100 == 99, k % 5 == 4, k % 2 == 1, !hold && strobe_of(sel_m, k), new_sel});
    sel_m = new_sel;
    k++;
    cycles(10 - used);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ena100hz) begin
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick at cyc=%0d actual=1 required=0", cyc);
      end else begin
        e = q.pop_front();
        chk("tick_cyc", cyc, e.cyc);
        chk("ena1hz", ena1hz, e.e1);
        chk("ena20hz", ena20hz, e.e20);
        chk("ena50hz", ena50hz, e.e50);
        chk("ena_db", ena_db, e.db);
        chk("sel_at_tick", sel, e.sel);
        chk("busy_at_tick", busy, 0);
      end
    end else if (ena1hz | ena20hz | ena50hz | ena_db) begin
      errors++;
      $display("FAIL stray_strobe at cyc=%0d actual=%b%b%b%b required=0000", cyc, ena1hz, ena20hz, ena50hz, ena_db);
    end
  end
  initial begin
    cycles(3);
    reset_chk();
    rst = 0;
    repeat (100) period(0, RATE_1HZ);
    period(1, RATE_20HZ);
    repeat (5) period(0, RATE_20HZ);
    period(2, RATE_1HZ);
    period(2, RATE_100HZ);
    period(3, RATE_100HZ);
    period(4, RATE_100HZ);
    repeat (2) period(0, RATE_100HZ);
    hold = 1;
    repeat (3) period(0, RATE_100HZ);
    hold = 0;
    repeat (2) period(0, RATE_100HZ);
    cycles(3);
    btn_next = 1;
    cycles(1);
    chk("busy_before_reset", busy, 1);
    rst = 1;
    cycles(1);
    reset_chk();
    cycles(2);
    rst = 0;
    k = 0;
    sel_m = RATE_1HZ;
    repeat (2) period(0, RATE_1HZ);
    btn_next = 0;
    period(0, RATE_1HZ);
    period(1, RATE_20HZ);
    cycles(2);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
